// File: rtl/linear_interp_mc.sv
// Multi-channel linear-interpolating rate converter with one time-multiplexed multiplier.
// Optional build macro LINTERP_CLAMP_EN clamps the snapshot phase to the measured period.
module linear_interp_mc #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned OUT_DIV = 512
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 run,
  input  logic                                 din_en,
  input  logic [NUM_CH*DATA_W-1:0]             din,
  output logic                                 dout_valid,
  output logic [NUM_CH*(DATA_W+CNT_W+1)-1:0]   dout,
  output logic                                 primed,
  output logic                                 busy
);

  localparam int unsigned OUT_W  = DATA_W + CNT_W + 1;
  localparam int unsigned PROD_W = DATA_W + CNT_W;
  localparam int unsigned DIV_W  = $clog2(OUT_DIV);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (OUT_DIV < 3 * NUM_CH + 2) begin : g_div_chk
    $error("linear_interp_mc: OUT_DIV must be >= 3*NUM_CH+2");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_ch_chk
    $error("linear_interp_mc: NUM_CH must be in 1..8");
  end

  typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL0, S_ACC, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         ph_q, ph_d, n_q, n_d, k_q, k_d, nn_q, nn_d;
  logic [1:0]               prime_cnt_q, prime_cnt_d;
  logic                     primed_q, primed_d, busy_q, busy_d;
  logic                     dout_valid_q, dout_valid_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [DATA_W-1:0] x0_q [NUM_CH], x0_d [NUM_CH];
  logic signed [DATA_W-1:0] x1_q [NUM_CH], x1_d [NUM_CH];
  logic signed [DATA_W-1:0] a0_q [NUM_CH], a0_d [NUM_CH];
  logic signed [DATA_W-1:0] a1_q [NUM_CH], a1_d [NUM_CH];
  logic signed [PROD_W-1:0] p_q, p_d, acc_q, acc_d;
  logic signed [OUT_W-1:0]  res_q [NUM_CH], res_d [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]  dout_q, dout_d;

  logic                     tick_c;
  logic [CNT_W-1:0]         coef_b_c, mul_b_c;
  logic signed [DATA_W-1:0] mul_a_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [OUT_W-1:0]  sum_c;

  // Shared multiplier: MUL1 weights the older sample by b, MUL0 the newer by a.
  always_comb begin
    coef_b_c = nn_q - k_q;
    if (state_q == S_MUL1) begin
      mul_a_c = a1_q[ch_q];
      mul_b_c = coef_b_c;
    end else begin
      mul_a_c = a0_q[ch_q];
      mul_b_c = k_q;
    end
    prod_c = PROD_W'(mul_a_c) * PROD_W'($signed({1'b0, mul_b_c}));
    sum_c  = OUT_W'(acc_q) + OUT_W'(p_q);
    tick_c = run && (div_q == DIV_W'(OUT_DIV - 1));
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    n_d          = n_q;
    k_d          = k_q;
    nn_d         = nn_q;
    prime_cnt_d  = prime_cnt_q;
    div_d        = div_q;
    ch_d         = ch_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    a0_d         = a0_q;
    a1_d         = a1_q;
    p_d          = p_q;
    acc_d        = acc_q;
    res_d        = res_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    // Input period measurement and sample history, independent of run.
    if (din_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        x1_d[c] = x0_q[c];
        x0_d[c] = $signed(din[c*DATA_W +: DATA_W]);
      end
      n_d  = ph_q + CNT_W'(1);
      ph_d = '0;
    end else if (ph_q != '1) begin
      ph_d = ph_q + CNT_W'(1);
    end

    if (!run) begin
      prime_cnt_d = '0;
      div_d       = '0;
    end else begin
      if (din_en && prime_cnt_q != 2'd2) prime_cnt_d = prime_cnt_q + 2'd1;
      div_d = (div_q == DIV_W'(OUT_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (tick_c && primed_q) begin
`ifdef LINTERP_CLAMP_EN
          k_d = (ph_q > n_q) ? n_q : ph_q;
`else
          k_d = ph_q;
`endif
          nn_d    = n_q;
          a0_d    = x0_q;
          a1_d    = x1_q;
          ch_d    = '0;
          state_d = S_MUL1;
        end
      end
      S_MUL1: begin
        p_d     = prod_c;
        state_d = S_MUL0;
      end
      S_MUL0: begin
        acc_d   = p_q;
        p_d     = prod_c;
        state_d = S_ACC;
      end
      S_ACC: begin
        res_d[ch_q] = sum_c;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          for (int c = 0; c < NUM_CH; c++) dout_d[c*OUT_W +: OUT_W] = res_d[c];
          dout_valid_d = 1'b1;
          state_d      = S_OUT;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_MUL1;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort discards any in-flight result; dout keeps its last value.
    if (!run) begin
      state_d      = S_IDLE;
      dout_valid_d = 1'b0;
      dout_d       = dout_q;
    end

    primed_d = (prime_cnt_d == 2'd2);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ph_q         <= '0;
      n_q          <= '0;
      k_q          <= '0;
      nn_q         <= '0;
      prime_cnt_q  <= '0;
      primed_q     <= 1'b0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      div_q        <= '0;
      ch_q         <= '0;
      p_q          <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        x0_q[c]  <= '0;
        x1_q[c]  <= '0;
        a0_q[c]  <= '0;
        a1_q[c]  <= '0;
        res_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      n_q          <= n_d;
      k_q          <= k_d;
      nn_q         <= nn_d;
      prime_cnt_q  <= prime_cnt_d;
      primed_q     <= primed_d;
      busy_q       <= busy_d;
      dout_valid_q <= dout_valid_d;
      div_q        <= div_d;
      ch_q         <= ch_d;
      p_q          <= p_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      a0_q         <= a0_d;
      a1_q         <= a1_d;
      res_q        <= res_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign primed     = primed_q;
  assign busy       = busy_q;

endmodule
